// File: rtl/ex_mdu.sv
// ex_mdu: RV32M multi-cycle multiply/divide unit beside the EX-stage ALU.
// Optional last-divide result cache is enabled by defining EX_MDU_DIVCACHE_EN.
module ex_mdu #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            reg_we_o
);
    localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(PD - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      rd_q, rd_d, rdp_q;
    logic            remsel_q, negq_q, negr_q;
    logic [XLEN-1:0] dvs_q, quo_q, quo_d, rem_q, rem_d;
    logic [XLEN-1:0] pipe_q [PD];

    logic            accept, is_mul, sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, hit, div_last;
    logic [XLEN-1:0] a_mag, b_mag, mul_res, spec_res, hit_res;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] step_quo, step_rem, q_fin, r_fin;

    assign accept = start_i & ~flush_i & (state_q == S_IDLE);
    assign is_mul = ~op_i[2];
    assign sgn    = ~op_i[0];
    assign a_neg  = sgn & op_a_i[XLEN-1];
    assign b_neg  = sgn & op_b_i[XLEN-1];
    assign a_mag  = a_neg ? -op_a_i : op_a_i;
    assign b_mag  = b_neg ? -op_b_i : op_b_i;

    assign div_zero = (op_b_i == '0);
    assign div_ovf  = sgn & (op_a_i == SMIN) & (&op_b_i);
    assign spec_res = op_i[1] ? (div_zero ? op_a_i : '0)
                              : (div_zero ? '1 : op_a_i);

    // Sign-extend to 2*XLEN so a single unsigned multiply covers all four ops.
    assign ma = {{XLEN{(op_i[1:0] != 2'b11) & op_a_i[XLEN-1]}}, op_a_i};
    assign mb = {{XLEN{~op_i[1] & op_b_i[XLEN-1]}}, op_b_i};
    assign prod = ma * mb;
    assign mul_res = (op_i[1:0] == 2'b00) ? prod[XLEN-1:0]
                                          : prod[2*XLEN-1:XLEN];

    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign step_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign q_fin    = negq_q ? -step_quo : step_quo;
    assign r_fin    = negr_q ? -step_rem : step_rem;
    assign div_last = (state_q == S_DIV) & ~flush_i & (cnt_q == DIV_LAST);

`ifdef EX_MDU_DIVCACHE_EN
    logic            cv_q, cs_q, sgn_q;
    logic [XLEN-1:0] ca_q, cb_q, cq_q, cr_q, a_q, b_q;

    assign hit = cv_q & (ca_q == op_a_i) & (cb_q == op_b_i)
               & (cs_q == sgn);
    assign hit_res = op_i[1] ? cr_q : cq_q;

    // Written only on a completed normal divide, so flushes leave it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q  <= 1'b0;
            cs_q  <= 1'b0;
            sgn_q <= 1'b0;
            ca_q  <= '0;
            cb_q  <= '0;
            cq_q  <= '0;
            cr_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            if (accept) begin
                a_q   <= op_a_i;
                b_q   <= op_b_i;
                sgn_q <= sgn;
            end
            if (div_last) begin
                cv_q <= 1'b1;
                ca_q <= a_q;
                cb_q <= b_q;
                cs_q <= sgn_q;
                cq_q <= q_fin;
                cr_q <= r_fin;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rd_d    = rd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (is_mul) begin
                        if (MUL_LAT == 1) begin
                            state_d = S_DONE;
                            res_d   = mul_res;
                            rd_d    = rd_i;
                        end else begin
                            state_d = S_MUL;
                        end
                    end else if (div_zero | div_ovf) begin
                        state_d = S_DONE;
                        res_d   = spec_res;
                        rd_d    = rd_i;
                    end else if (hit) begin
                        state_d = S_DONE;
                        res_d   = hit_res;
                        rd_d    = rd_i;
                    end else begin
                        state_d = S_DIV;
                        quo_d   = a_mag;
                        rem_d   = '0;
                    end
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_DONE;
                    res_d   = pipe_q[PD-1];
                    rd_d    = rdp_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    if (cnt_q == DIV_LAST) begin
                        state_d = S_DONE;
                        res_d   = remsel_q ? r_fin : q_fin;
                        rd_d    = rdp_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            rdp_q    <= '0;
            remsel_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            if (accept) begin
                rdp_q     <= rd_i;
                remsel_q  <= op_i[1];
                negq_q    <= a_neg ^ b_neg;
                negr_q    <= a_neg;
                dvs_q     <= b_mag;
                pipe_q[0] <= mul_res;
            end
            for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign stall_req_o = accept | (state_q == S_MUL) | (state_q == S_DIV);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = res_q;
    assign rd_o        = rd_q;
    assign reg_we_o    = done_o & (rd_q != '0);

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed table, corner sequences and random ops for ex_mdu.
// Expected results come from 64-bit arithmetic over the RV32M rules.
module tb_ex_mdu;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 1;
`ifdef EX_MDU_DIVCACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = DIV_LAT;
`endif
    localparam logic [31:0] SMIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, stall_req_o, done_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
        .flush_i(flush_i), .busy_o(busy_o), .stall_req_o(stall_req_o),
        .done_o(done_o), .result_o(result_o), .rd_o(rd_o),
        .reg_we_o(reg_we_o)
    );

    int nvec = 0;
    int nerr = 0;
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd = '0;
`ifdef EX_MDU_DIVCACHE_EN
    bit          cv = 1'b0;
    bit          cs = 1'b0;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(b); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == SMIN && b == '1) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == SMIN && b == '1) return '0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected latency; also tracks the last completed normal divide.
    function automatic int cache_note(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == SMIN && b == '1) return 1;
`ifdef EX_MDU_DIVCACHE_EN
        if (cv && ca == a && cb == b && cs == !op[0]) return 1;
        cv = 1'b1;
        ca = a;
        cb = b;
        cs = !op[0];
`endif
        return DIV_LAT;
    endfunction

    task automatic run(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat,
                       input string tag);
        int cyc;
        bit stall_ok;
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        op_a_i = a;
        op_b_i = b;
        rd_i = rd;
        #1 chk({tag, ".stall0"}, 32'(stall_req_o), 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        stall_ok = 1'b1;
        while (!done_o && cyc < 100) begin
            if (!stall_req_o || !busy_o) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".stall"}, 32'(stall_ok), 32'd1);
        chk({tag, ".lat"}, 32'(cyc), 32'(lat));
        chk({tag, ".res"}, result_o, exp);
        chk({tag, ".rd"}, 32'(rd_o), 32'(rd));
        chk({tag, ".we"}, 32'(reg_we_o), 32'(rd != 0));
        chk({tag, ".stalldone"}, 32'(stall_req_o), 32'd0);
        last_exp = exp;
        last_rd = rd;
    endtask

    initial begin
        logic [31:0] a, b, ra, rb, exp, neg;
        logic [2:0]  op;
        int lat, cyc, sel;
        bit saw_done;

        tbl[0]  = '{3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT};
        tbl[1]  = '{3'd1, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFFF, MUL_LAT};
        tbl[2]  = '{3'd3, 32'd7, 32'hFFFFFFFD, 5'd6, 32'h00000006, MUL_LAT};
        tbl[3]  = '{3'd4, 32'hFFFFFFEC, 32'd3, 5'd7, 32'hFFFFFFFA, DIV_LAT};
        tbl[4]  = '{3'd6, 32'hFFFFFFEC, 32'd3, 5'd8, 32'hFFFFFFFE, HIT_LAT};
        tbl[5]  = '{3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1};
        tbl[6]  = '{3'd6, SMIN, 32'hFFFFFFFF, 5'd10, 32'h0, 1};
        tbl[7]  = '{3'd4, SMIN, 32'hFFFFFFFF, 5'd11, SMIN, 1};
        tbl[8]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, MUL_LAT};
        tbl[9]  = '{3'd4, 32'd1000, 32'd9, 5'd2, 32'd111, DIV_LAT};
        tbl[10] = '{3'd6, 32'd1000, 32'd9, 5'd3, 32'd1, HIT_LAT};
        tbl[11] = '{3'd5, 32'd1000, 32'd9, 5'd4, 32'd111, DIV_LAT};
        tbl[12] = '{3'd7, 32'd1000, 32'd9, 5'd5, 32'd1, HIT_LAT};
        tbl[13] = '{3'd0, 32'd3, 32'd4, 5'd0, 32'd12, MUL_LAT};

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.res", result_o, 32'd0);
        chk("rst.rd", 32'(rd_o), 32'd0);
        chk("rst.we", 32'(reg_we_o), 32'd0);
        chk("rst.stall", 32'(stall_req_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            void'(cache_note(tbl[i].op, tbl[i].a, tbl[i].b));
            run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp,
                tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // Flush a divide at cycle 10: no done, old result held.
        @(negedge clk);
        start_i = 1'b1;
        op_i = 3'd5;
        op_a_i = 32'd100;
        op_b_i = 32'd7;
        rd_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done_o) saw_done = 1'b1;
            @(negedge clk);
        end
        if (done_o) saw_done = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        if (done_o) saw_done = 1'b1;
        chk("flush.busy", 32'(busy_o), 32'd0);
        chk("flush.res", result_o, last_exp);
        chk("flush.rd", 32'(rd_o), 32'(last_rd));
        repeat (3) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        chk("flush.nodone", 32'(saw_done), 32'd0);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE,
            MUL_LAT, "flushmul");

        // start_i held high through a busy divide with other operands.
        neg = -32'd12345;
        lat = cache_note(3'd4, neg, 32'd77);
        exp = ref_res(3'd4, neg, 32'd77);
        @(negedge clk);
        start_i = 1'b1;
        op_i = 3'd4;
        op_a_i = neg;
        op_b_i = 32'd77;
        rd_i = 5'd12;
        @(negedge clk);
        op_i = 3'd6;
        op_a_i = 32'd999;
        op_b_i = 32'd5;
        rd_i = 5'd3;
        cyc = 1;
        while (!done_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("hold.lat", 32'(cyc), 32'(lat));
        chk("hold.res", result_o, exp);
        chk("hold.rd", 32'(rd_o), 32'd12);
        @(negedge clk);
        chk("hold.idle", 32'(busy_o), 32'd0);
        last_exp = exp;
        last_rd = 5'd12;

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1;
        op_i = 3'd4;
        op_a_i = 32'd1234567;
        op_b_i = 32'd89;
        rd_i = 5'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.busy", 32'(busy_o), 32'd0);
        chk("mrst.done", 32'(done_o), 32'd0);
        chk("mrst.res", result_o, 32'd0);
        chk("mrst.rd", 32'(rd_o), 32'd0);
        chk("mrst.stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef EX_MDU_DIVCACHE_EN
        cv = 1'b0;
`endif

        ra = 32'd1;
        rb = 32'd1;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            case (sel)
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = SMIN; b = 32'hFFFFFFFF; end
                2: begin a = ra; b = rb; end
                3: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            ra = a;
            rb = b;
            lat = cache_note(op, a, b);
            exp = ref_res(op, a, b);
            run(op, a, b, 5'($urandom_range(0, 31)), exp, lat,
                $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
